// File: rtl/cbd_noise_sampler_pkg.sv
// Shared constants, FSM state type and slot helper for the centred-binomial noise sampler.
// Ring dimension, modulus and per-word slot counts for eta=2 / eta=3.
package cbd_noise_sampler_pkg;

  localparam int KYBER_Q    = 3329;
  localparam int KYBER_N    = 256;
  localparam int ETA2_SLOTS = 6;
  localparam int ETA3_SLOTS = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic logic [2:0] last_slot(input logic eta3);
    return eta3 ? 3'(ETA3_SLOTS - 1) : 3'(ETA2_SLOTS - 1);
  endfunction

endpackage

// File: rtl/cbd_noise_sampler_coeff.sv
// Combinational CBD sample: two popcounts, their difference, and the fold into 0..KQ-1.
// eta=2 uses bits6[3:0] as two 2-bit halves; eta=3 uses bits6[5:0] as two 3-bit halves.
module cbd_noise_sampler_coeff
  import cbd_noise_sampler_pkg::*;
#(
  parameter int KQ = KYBER_Q,
  parameter int CW = 12
) (
  input  logic          eta3,
  input  logic [5:0]    bits6,
  output logic [CW-1:0] coeff
);

  logic        [1:0] pa;
  logic        [1:0] pb;
  logic signed [2:0] v;

  function automatic logic [CW-1:0] fold_modq(input logic signed [2:0] s);
    logic signed [CW+1:0] w;
    w = {{(CW-1){s[2]}}, s};
    if (s[2]) w = w + $signed((CW+2)'(KQ));
    return w[CW-1:0];
  endfunction

  always_comb begin
    if (eta3) begin
      pa = {1'b0, bits6[0]} + {1'b0, bits6[1]} + {1'b0, bits6[2]};
      pb = {1'b0, bits6[3]} + {1'b0, bits6[4]} + {1'b0, bits6[5]};
    end else begin
      pa = {1'b0, bits6[0]} + {1'b0, bits6[1]};
      pb = {1'b0, bits6[2]} + {1'b0, bits6[3]};
    end
    v     = $signed({1'b0, pa}) - $signed({1'b0, pb});
    coeff = fold_modq(v);
  end

endmodule

// File: rtl/cbd_noise_sampler.sv
// Centred-binomial noise sampler: pulls 25-bit words from the hash-core FIFO and
// emits KN coefficients mod KQ over valid/ready, one per cycle within a word.
module cbd_noise_sampler
  import cbd_noise_sampler_pkg::*;
#(
  parameter int KQ = KYBER_Q,
  parameter int KN = KYBER_N,
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          fifo_empty,
  output logic          fifo_req,
  input  logic [24:0]   fifo_dout,
  output logic          coeff_valid,
  input  logic          coeff_ready,
  output logic [CW-1:0] coeff,
  output logic [7:0]    coeff_idx,
  output logic          busy,
  output logic          poly_done,
  output logic          mode_err
);

  state_e      state_q;
  logic [23:0] buf_q;
  logic [2:0]  slot_q;
  logic [7:0]  idx_q;
  logic        eta3_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [4:0]  shamt;
  logic [5:0]  bits6;

  // Slot k starts at bit 4k (eta=2) or 6k (eta=3).
  assign shamt = ({2'b00, slot_q} << 2) + (eta3_q ? ({2'b00, slot_q} << 1) : 5'd0);
  assign bits6 = 6'(buf_q >> shamt);

  cbd_noise_sampler_coeff #(.KQ(KQ), .CW(CW)) u_coeff (
    .eta3  (eta3_q),
    .bits6 (bits6),
    .coeff (coeff)
  );

  // The FIFO returns data the cycle after the read, which is exactly the LOAD cycle.
  assign fifo_req    = (state_q == S_FETCH) && !fifo_empty;
  assign coeff_valid = (state_q == S_EMIT);
  assign coeff_idx   = idx_q;
  assign busy        = busy_q;
  assign poly_done   = done_q;
  assign mode_err    = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      eta3_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            slot_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        S_FETCH: begin
          if (!fifo_empty) state_q <= S_LOAD;
        end
        S_LOAD: begin
          buf_q   <= fifo_dout[23:0];
          slot_q  <= '0;
          state_q <= S_EMIT;
          // Mode is fixed by the first word; later disagreement only flags an error.
          if (idx_q == 8'd0) eta3_q <= fifo_dout[24];
          else if (fifo_dout[24] != eta3_q) err_q <= 1'b1;
        end
        S_EMIT: begin
          if (coeff_ready) begin
            idx_q  <= idx_q + 8'd1;
            slot_q <= slot_q + 3'd1;
            if (idx_q == 8'(KN - 1)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (slot_q == last_slot(eta3_q)) begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_noise_sampler.sv
// Bench for cbd_noise_sampler: FIFO model with empty gaps, random backpressure,
// and a word-level CBD reference model computed from popcounts.
module tb_cbd_noise_sampler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        fifo_empty = 1'b1;
  logic        fifo_req;
  logic [24:0] fifo_dout;
  logic        coeff_valid;
  logic        coeff_ready = 1'b1;
  logic [11:0] coeff;
  logic [7:0]  coeff_idx;
  logic        busy;
  logic        poly_done;
  logic        mode_err;

  cbd_noise_sampler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .fifo_empty  (fifo_empty),
    .fifo_req    (fifo_req),
    .fifo_dout   (fifo_dout),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .coeff       (coeff),
    .coeff_idx   (coeff_idx),
    .busy        (busy),
    .poly_done   (poly_done),
    .mode_err    (mode_err)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [24:0] wq[$];
  logic [24:0] fq[$];
  logic [11:0] exp_c[$];
  logic [11:0] obs_c[$];
  logic [7:0]  obs_i[$];
  bit          err_at[256];
  int          exp_words;
  int          req_cnt  = 0;
  int          bad_req  = 0;
  int          done_cnt = 0;
  int          gap      = 0;
  bit          gaps_en  = 1'b0;
  bit          rdy_rand = 1'b0;

  // FIFO read side: data appears the cycle after a read; optional empty gaps after each read.
  always @(posedge clk) begin
    if (fifo_req) begin
      if (fifo_empty) bad_req++;
      if (fq.size() > 0) fifo_dout <= fq.pop_front();
      req_cnt++;
      if (gaps_en) gap = $urandom_range(0, 5);
    end else if (gap > 0) begin
      gap = gap - 1;
    end
  end

  // Downstream sink and FIFO flag driver, updated mid-cycle.
  always @(negedge clk) begin
    coeff_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_empty  = (fq.size() == 0) || (gap > 0);
    #1;
    if (coeff_valid) err_at[coeff_idx] = mode_err;
    if (coeff_valid && coeff_ready) begin
      obs_c.push_back(coeff);
      obs_i.push_back(coeff_idx);
    end
    if (poly_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: coefficient i comes from word i/slots, group i%slots; mode from word 0.
  task automatic build_expected();
    int slots, width, half, w, k, a, b, v;
    int r, grp, mask;
    bit e3;
    exp_c.delete();
    e3    = wq[0][24];
    slots = e3 ? 4 : 6;
    width = e3 ? 6 : 4;
    half  = width / 2;
    mask  = (1 << half) - 1;
    for (int i = 0; i < 256; i++) begin
      w   = i / slots;
      k   = i % slots;
      r   = int'(wq[w][23:0]);
      grp = (r >> (width * k)) & ((1 << width) - 1);
      a   = $countones(grp & mask);
      b   = $countones((grp >> half) & mask);
      v   = a - b;
      exp_c.push_back(v < 0 ? 12'(3329 + v) : 12'(v));
    end
    exp_words = (256 + slots - 1) / slots;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_fifo_req"}, 32'(fifo_req), 32'd0);
    check({tag, "_valid"},    32'(coeff_valid), 32'd0);
    check({tag, "_coeff"},    32'(coeff), 32'd0);
    check({tag, "_idx"},      32'(coeff_idx), 32'd0);
    check({tag, "_busy"},     32'(busy), 32'd0);
    check({tag, "_done"},     32'(poly_done), 32'd0);
    check({tag, "_mode_err"}, 32'(mode_err), 32'd0);
  endtask

  task automatic run_poly(input string tag, input bit gaps, input bit rdy, input bit restart);
    int cyc;
    build_expected();
    fq = wq;
    fq.push_back({wq[0][24], 24'hFFFFFF});
    fq.push_back({wq[0][24], 24'hFFFFFF});
    obs_c.delete();
    obs_i.delete();
    for (int i = 0; i < 256; i++) err_at[i] = 1'b0;
    req_cnt  = 0;
    bad_req  = 0;
    done_cnt = 0;
    gaps_en  = gaps;
    rdy_rand = rdy;
    gap      = gaps ? $urandom_range(0, 5) : 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    check({tag, "_err_cleared"},      32'(mode_err), 32'd0);
    if (restart) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_poly_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_coeff_count"},     32'(obs_c.size()), 32'd256);
    if (obs_c.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        check($sformatf("%s_coeff[%0d]", tag, i), 32'(obs_c[i]), 32'(exp_c[i]));
        check($sformatf("%s_idx[%0d]", tag, i),   32'(obs_i[i]), 32'(i));
      end
    end
    check({tag, "_fifo_reads"},       32'(req_cnt), 32'(exp_words));
    check({tag, "_req_while_empty"},  32'(bad_req), 32'd0);
    check({tag, "_busy_end"},         32'(busy), 32'd0);
    fq.delete();
    gaps_en  = 1'b0;
    rdy_rand = 1'b0;
    gap      = 0;
  endtask

  initial begin
    int cyc;
    rst_n     = 1'b0;
    start     = 1'b0;
    fifo_dout = '0;
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // eta=2, all-zero words
    wq.delete();
    for (int i = 0; i < 43; i++) wq.push_back(25'h0000000);
    run_poly("eta2_zero", 1'b0, 1'b0, 1'b0);

    // eta=2 hand patterns
    wq.delete();
    wq.push_back(25'h000000C);
    wq.push_back(25'h0000003);
    for (int i = 2; i < 43; i++) wq.push_back(25'h0000000);
    run_poly("eta2_pat", 1'b0, 1'b0, 1'b0);
    if (obs_c.size() > 6) begin
      check("eta2_pat_minus2", 32'(obs_c[0]), 32'h0CFF);
      check("eta2_pat_plus2",  32'(obs_c[6]), 32'h0002);
    end

    // eta=3 hand patterns
    wq.delete();
    wq.push_back(25'h1000038);
    wq.push_back(25'h1000007);
    for (int i = 2; i < 64; i++) wq.push_back(25'h1000000);
    run_poly("eta3_pat", 1'b0, 1'b0, 1'b0);
    if (obs_c.size() > 4) begin
      check("eta3_pat_minus3", 32'(obs_c[0]), 32'h0CFE);
      check("eta3_pat_plus3",  32'(obs_c[4]), 32'h0003);
    end

    // Random words with backpressure, empty gaps and a start pulse while busy
    wq.delete();
    for (int i = 0; i < 43; i++) wq.push_back({1'b0, 24'($urandom)});
    run_poly("eta2_rand", 1'b1, 1'b1, 1'b1);
    wq.delete();
    for (int i = 0; i < 64; i++) wq.push_back({1'b1, 24'($urandom)});
    run_poly("eta3_rand", 1'b1, 1'b1, 1'b1);

    // Mode flip on word 10: error visible from idx 60, samples keep eta=2
    wq.delete();
    for (int i = 0; i < 43; i++) wq.push_back({1'b0, 24'($urandom)});
    wq[10][24] = 1'b1;
    run_poly("mode_err", 1'b0, 1'b1, 1'b0);
    check("mode_err_before_word10", 32'(err_at[59]), 32'd0);
    check("mode_err_at_word10",     32'(err_at[60]), 32'd1);
    check("mode_err_sticky",        32'(mode_err), 32'd1);

    // Reset while emitting coefficient 100
    wq.delete();
    for (int i = 0; i < 64; i++) wq.push_back({1'b1, 24'($urandom)});
    fq       = wq;
    done_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(coeff_valid && coeff_idx == 8'd100) && cyc < 5000) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    check("rst_reached_idx100", 32'(coeff_idx), 32'd100);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    fq.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    check("rst_no_stray_done", 32'(done_cnt), 32'd0);
    wq.delete();
    for (int i = 0; i < 43; i++) wq.push_back({1'b0, 24'($urandom)});
    run_poly("after_rst", 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
